fifo_axis_tx: RTL and testbench

Drains the read side of a first-word-fall-through FIFO (`empty_n`/`read`/`dout` handshake) and transmits the words as AXI4-Stream packets with generated `tlast`. It is the consumer end of an inter-task FIFO channel, bridging the FIFO into a stream-based sink (DMA, network or off-chip writer). The host supplies the packet length and packet count per job. The block runs at full throughput, and `tready` never feeds `fifo_read` combinationally.

---
 rtl/fifo_axis_pkg.sv | 19 +
 rtl/axis_buf2.sv | 86 ++++++++
 rtl/fifo_axis_tx.sv | 133 +++++++++++++
 tb/tb_fifo_axis_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_axis_pkg.sv
// ---------------------------------------------------------------------------
// fifo_axis_pkg
// Shared definitions for the FIFO-to-AXI4-Stream transmitter:
//   - state_t    : controller states (IDLE / RUN / FLUSH)
//   - BUF_DEPTH  : depth of the output skid buffer
//   - OCC_W      : width of the buffer occupancy count
// ---------------------------------------------------------------------------
package fifo_axis_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int BUF_DEPTH = 2;
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage : fifo_axis_pkg

// File: rtl/axis_buf2.sv
// ---------------------------------------------------------------------------
// axis_buf2
// Two-entry register FIFO carrying {data, last}. Entry 0 is always the head,
// so the stream outputs come straight from flops.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   push, push_data/last  write one entry (accepted when a slot is free or
//                         being freed by a simultaneous pop)
//   pop                   remove the head entry (ignored when empty)
//   occ                   registered occupancy, 0..2
//   head_valid/data/last  head entry; head_last is gated by head_valid
// ---------------------------------------------------------------------------
module axis_buf2
   import fifo_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [OCC_W-1:0]      occ,
   output logic                  head_valid,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last
);

   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [DATA_WIDTH-1:0] data_q [BUF_DEPTH];
   logic [DATA_WIDTH-1:0] data_d [BUF_DEPTH];
   logic                  last_q [BUF_DEPTH];
   logic                  last_d [BUF_DEPTH];

   logic             do_pop;
   logic             do_push;
   logic [OCC_W-1:0] wr_slot;

   assign do_pop  = pop && (occ_q != '0);
   // A push into a full buffer is legal only if the head leaves this cycle.
   assign do_push = push && ((occ_q < OCC_W'(BUF_DEPTH)) || do_pop);
   // Slot index after the (optional) shift caused by the pop.
   assign wr_slot = occ_q - OCC_W'(do_pop);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      occ_d  = occ_q;
      data_d = data_q;
      last_d = last_q;

      if (do_pop) begin
         data_d[0] = data_q[1];
         last_d[0] = last_q[1];
      end

      if (do_push) begin
         data_d[wr_slot[0]] = push_data;
         last_d[wr_slot[0]] = push_last;
      end

      occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
   end

   // NOTE: the storage is reset too, because the head entry drives tdata and must read 0 out of reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            data_q[i] <= '0;
            last_q[i] <= 1'b0;
         end
      end else begin
         // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
         occ_q  <= occ_d;
         data_q <= data_d;
         last_q <= last_d;
      end
   end

   assign occ        = occ_q;
   assign head_valid = (occ_q != '0);
   assign head_data  = data_q[0];
   assign head_last  = last_q[0] && head_valid;

endmodule : axis_buf2

// File: rtl/fifo_axis_tx.sv
// ---------------------------------------------------------------------------
// fifo_axis_tx
// Drains an FWFT FIFO read port and transmits the words as AXI4-Stream
// packets of pkt_len beats, pkt_cnt packets per job, with generated tlast.
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   start, pkt_len, pkt_cnt     job request and its parameters (idle only)
//   busy, done                  job in progress / one-cycle completion pulse
//   fifo_empty_n, fifo_dout     FIFO head valid and data
//   fifo_read_ce, fifo_read     read enable (== busy) and pop request
//   m_axis_*                    AXI4-Stream master
// fifo_read depends only on registered state, never on m_axis_tready; the
// 2-entry output buffer absorbs the one-cycle reaction lag.
// ---------------------------------------------------------------------------
module fifo_axis_tx
   import fifo_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [LEN_WIDTH-1:0]  pkt_cnt,
   output logic                  busy,
   output logic                  done,
   input  logic                  fifo_empty_n,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_read_ce,
   output logic                  fifo_read,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready
);

   state_t               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [LEN_WIDTH-1:0] beats_left_q, beats_left_d;
   logic [LEN_WIDTH-1:0] pkts_left_q, pkts_left_d;
   logic                 done_q, done_d;

   logic [OCC_W-1:0] occ;
   logic             pop_fifo;
   logic             drain;
   logic             is_last;

   assign fifo_read = (state_q == ST_RUN) && (occ < OCC_W'(BUF_DEPTH));
   assign pop_fifo  = fifo_read && fifo_empty_n;
   assign drain     = m_axis_tvalid && m_axis_tready;
   assign is_last   = (beats_left_q == LEN_WIDTH'(1));

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      beats_left_d = beats_left_q;
      pkts_left_d  = pkts_left_q;
      done_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d        = pkt_len;
               beats_left_d = pkt_len;
               pkts_left_d  = pkt_cnt;
               // Empty jobs skip RUN so the counters never see zero.
               if (pkt_len == '0 || pkt_cnt == '0) state_d = ST_FLUSH;
               else                                state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (pop_fifo) begin
               if (is_last) begin
                  beats_left_d = len_q;
                  pkts_left_d  = pkts_left_q - LEN_WIDTH'(1);
                  if (pkts_left_q == LEN_WIDTH'(1)) state_d = ST_FLUSH;
               end else begin
                  beats_left_d = beats_left_q - LEN_WIDTH'(1);
               end
            end
         end

         ST_FLUSH: begin
            // Leave as the final beat handshakes, so busy drops together
            // with the done pulse one cycle after that handshake.
            if (occ == '0 || (occ == OCC_W'(1) && drain)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         len_q        <= '0;
         beats_left_q <= '0;
         pkts_left_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         beats_left_q <= beats_left_d;
         pkts_left_q  <= pkts_left_d;
         done_q       <= done_d;
      end
   end

   assign busy         = (state_q != ST_IDLE);
   assign fifo_read_ce = busy;
   assign done         = done_q;

   axis_buf2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buf (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (pop_fifo),
      .push_data  (fifo_dout),
      .push_last  (is_last),
      .pop        (drain),
      .occ        (occ),
      .head_valid (m_axis_tvalid),
      .head_data  (m_axis_tdata),
      .head_last  (m_axis_tlast)
   );

endmodule : fifo_axis_tx

// File: tb/tb_fifo_axis_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_axis_tx
// Drives fifo_axis_tx from a queue-backed FWFT FIFO model and collects the
// stream beats. Expected beats are the first pkt_len*pkt_cnt source words,
// with tlast on every pkt_len-th beat.
// ---------------------------------------------------------------------------
module tb_fifo_axis_tx;

   localparam int DW = 32;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] pkt_len = '0;
   logic [LW-1:0] pkt_cnt = '0;
   logic          busy;
   logic          done;
   logic          fifo_empty_n = 1'b0;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_read_ce;
   logic          fifo_read;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready = 1'b0;

   fifo_axis_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .pkt_len       (pkt_len),
      .pkt_cnt       (pkt_cnt),
      .busy          (busy),
      .done          (done),
      .fifo_empty_n  (fifo_empty_n),
      .fifo_dout     (fifo_dout),
      .fifo_read_ce  (fifo_read_ce),
      .fifo_read     (fifo_read),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [LW-1:0] len;
      logic [LW-1:0] cnt;
      int            rmode;      // 0 always ready, 1 toggle 1,0,..., 2 random, 3 never
      int            emode;      // 0 always, 1 pattern 1,0,0,..., 2 random
      bit            restart;    // pulse start (len 7) while busy
      int            exp_beats;
      int            exp_lasts;
      int            exp_done;   // steps from start to done, 0 = not checked
   } vec_t;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] src[$];
   beat_t         got[$];
   int pops, hss, step_idx, last_hs_step, done_step, done_cnt;
   int viol_stab, viol_ahead, viol_ce;
   bit busy_at1, busy_at_done;
   bit prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // One clock cycle: drive at negedge, observe, let the edge happen,
   // then retire the popped source word. Starts and ends at a negedge.
   task automatic step(input int rmode, input int emode);
      bit rdy, en, do_pop, do_hs;
      beat_t b;
      case (rmode)
         0:       rdy = 1'b1;
         1:       rdy = (step_idx % 2 == 0);
         2:       rdy = 1'($urandom_range(0, 1));
         default: rdy = 1'b0;
      endcase
      case (emode)
         0:       en = 1'b1;
         1:       en = (step_idx % 3 == 0);
         default: en = 1'($urandom_range(0, 1));
      endcase
      m_axis_tready = rdy;
      fifo_empty_n  = en && (src.size() > 0);
      fifo_dout     = (src.size() > 0) ? src[0] : '0;
      #1;
      if (fifo_read_ce !== busy) viol_ce++;
      if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                         m_axis_tlast !== prev_last)) viol_stab++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      do_pop = fifo_empty_n && fifo_read;
      do_hs  = m_axis_tvalid && m_axis_tready;
      if (do_hs) begin
         b.data = m_axis_tdata;
         b.last = m_axis_tlast;
         got.push_back(b);
         hss++;
         last_hs_step = step_idx;
      end
      if (do_pop) pops++;
      if (pops - hss > 2) viol_ahead++;
      if (step_idx == 1) busy_at1 = busy;
      if (done === 1'b1) begin
         done_cnt++;
         if (done_step < 0) begin
            done_step    = step_idx;
            busy_at_done = busy;
         end
      end
      @(posedge clk);
      if (do_pop) void'(src.pop_front());
      @(negedge clk);
      step_idx++;
   endtask

   task automatic clear_stats();
      got.delete();
      pops = 0; hss = 0; step_idx = 0; last_hs_step = -1; done_step = -1; done_cnt = 0;
      viol_stab = 0; viol_ahead = 0; viol_ce = 0;
      busy_at1 = 1'b0; busy_at_done = 1'b1; prev_stall = 1'b0;
   endtask

   task automatic run_job(input vec_t v);
      logic [DW-1:0] model[$];
      int derr, nlast;
      bit exp_last;
      src.delete();
      for (int i = 0; i < v.exp_beats + 6; i++) src.push_back($urandom);
      model = src;
      clear_stats();
      start = 1'b1; pkt_len = v.len; pkt_cnt = v.cnt;
      step(v.rmode, v.emode);
      start = 1'b0; pkt_len = LW'($urandom); pkt_cnt = LW'($urandom);
      while (done_step < 0 && step_idx < 400) begin
         if (v.restart && step_idx == 3) begin
            start = 1'b1; pkt_len = LW'(7); pkt_cnt = LW'(1);
         end
         step(v.rmode, v.emode);
         start = 1'b0;
      end
      step(v.rmode, v.emode);   // done must be gone again here

      derr = 0; nlast = 0;
      for (int i = 0; i < got.size(); i++) begin
         exp_last = (v.len != 0) && ((i + 1) % int'(v.len) == 0);
         if (i >= model.size() || got[i].data !== model[i] || got[i].last !== exp_last) derr++;
         if (got[i].last) nlast++;
      end
      check("job_finished", done_step >= 0, 1);
      check("busy_after_start", busy_at1, 1);
      check("beats", got.size(), v.exp_beats);
      check("pops", pops, v.exp_beats);
      check("beat_content", derr, 0);
      check("tlast_count", nlast, v.exp_lasts);
      if (v.exp_beats > 0) check("done_after_last_hs", done_step, last_hs_step + 1);
      else                 check("done_empty_job", done_step, 2);
      if (v.exp_done != 0) check("done_latency", done_step, v.exp_done);
      check("done_width", done_cnt, 1);
      check("busy_at_done", busy_at_done, 0);
      check("stall_stability", viol_stab, 0);
      check("pops_ahead", viol_ahead, 0);
      check("read_ce_eq_busy", viol_ce, 0);
   endtask

   vec_t vecs[7];
   vec_t rv;

   initial begin
      //          len cnt  rdy en  rst beats lasts done
      vecs[0] = '{16'd4, 16'd2, 0, 0, 1'b0, 8, 2, 10};
      vecs[1] = '{16'd4, 16'd2, 1, 0, 1'b0, 8, 2, 0};
      vecs[2] = '{16'd3, 16'd1, 0, 1, 1'b0, 3, 1, 11};
      vecs[3] = '{16'd0, 16'd5, 0, 0, 1'b0, 0, 0, 2};
      vecs[4] = '{16'd5, 16'd0, 0, 0, 1'b0, 0, 0, 2};
      vecs[5] = '{16'd4, 16'd2, 0, 0, 1'b1, 8, 2, 10};
      vecs[6] = '{16'd1, 16'd3, 0, 0, 1'b0, 3, 3, 5};

      // Reset values
      reset_n = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_read_ce", fifo_read_ce, 0);
      check("rst_read", fifo_read, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tdata", m_axis_tdata, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_job(vecs[i]);

      // Randomized jobs against the queue model
      for (int j = 0; j < 12; j++) begin
         rv.len       = LW'($urandom_range(1, 5));
         rv.cnt       = LW'($urandom_range(1, 4));
         rv.rmode     = 2;
         rv.emode     = 2;
         rv.restart   = 1'b0;
         rv.exp_beats = int'(rv.len) * int'(rv.cnt);
         rv.exp_lasts = int'(rv.cnt);
         rv.exp_done  = 0;
         run_job(rv);
      end

      // Reset in the middle of a job with two beats buffered
      src.delete();
      for (int i = 0; i < 20; i++) src.push_back($urandom);
      clear_stats();
      start = 1'b1; pkt_len = LW'(4); pkt_cnt = LW'(2);
      step(3, 0);
      start = 1'b0;
      for (int i = 0; i < 4; i++) step(3, 0);
      check("stalled_pops", pops, 2);
      check("stalled_tvalid", m_axis_tvalid, 1);
      check("stalled_read", fifo_read, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_tvalid", m_axis_tvalid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_read", fifo_read, 0);
      @(negedge clk);
      reset_n = 1'b1;
      clear_stats();
      for (int i = 0; i < 6; i++) step(0, 0);
      check("postrst_pops", pops, 0);
      check("postrst_beats", hss, 0);
      check("postrst_busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fifo_axis_tx
